// File: rtl/pc_count_if.sv
`default_nettype none
// ============================================================================
// pc_count_if : branch/offset qualifiers in, program counter out
// Revision    : 1.0
// ============================================================================
interface pc_count_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] incrementOffset;
   logic             branch;
   logic [WIDTH-1:0] PC;

   modport master (
      output incrementOffset,
      output branch,
      input  PC
   );

   modport slave (
      input  incrementOffset,
      input  branch,
      output PC
   );
endinterface
`default_nettype wire

// File: rtl/pc_count.sv
`default_nettype none
// ============================================================================
// pc_count : fetch-stage program counter, sequential step or PC-relative branch
// Revision : 1.0
// ============================================================================
module pc_count #(
   parameter int WIDTH       = 8,
   parameter int STEP        = 4,
   parameter int RESET_VALUE = 0
) (
   input  wire logic    clk,
   input  wire logic    rst,
   pc_count_if.slave    bus
);
   localparam logic [WIDTH-1:0] c_step  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] r_pc;

   // Offset and PC share one width, so a plain modulo-2^WIDTH add already
   // applies the offset as sign-extended; wrap-around is intentional.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= c_reset;
      end else if (bus.branch) begin
         r_pc <= r_pc + bus.incrementOffset;
      end else begin
         r_pc <= r_pc + c_step;
      end
   end

   assign bus.PC = r_pc;
endmodule
`default_nettype wire

// File: tb/tb_pc_count.sv
`default_nettype none
// ============================================================================
// tb_pc_count : directed plan plus random traffic against a wrap-around model
// Revision    : 1.0
// ============================================================================
module tb_pc_count;
   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   pc_m;

   pc_count_if #(.WIDTH(WIDTH)) bus ();

   pc_count #(
      .WIDTH       (WIDTH),
      .STEP        (4),
      .RESET_VALUE (0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle, advance the model, compare; want >= 0 adds a fixed check.
   task automatic step(input logic r, input logic b, input logic [7:0] off,
                       input string tag, input int want);
      rst                 = r;
      bus.branch          = b;
      bus.incrementOffset = off;
      @(posedge clk);
      #1;
      if (r)
         pc_m = 0;
      else if (b)
         pc_m = (pc_m + int'($signed(off))) & 255;
      else
         pc_m = (pc_m + 4) & 255;
      tests++;
      assert (bus.PC === 8'(pc_m))
      else begin
         fails++;
         $error("FAIL %s model: observed %0d expected %0d", tag, bus.PC, pc_m);
      end
      if (want >= 0) begin
         tests++;
         assert (bus.PC === 8'(want))
         else begin
            fails++;
            $error("FAIL %s plan: observed %0d expected %0d", tag, bus.PC, want);
         end
      end
   endtask

   initial begin
      tests               = 0;
      fails               = 0;
      pc_m                = 0;
      rst                 = 1'b1;
      bus.branch          = 1'b1;
      bus.incrementOffset = 8'h10;

      step(1'b1, 1'b1, 8'h10, "reset0", 0);
      step(1'b1, 1'b1, 8'h10, "reset1", 0);

      step(1'b0, 1'b0, 8'h00, "seq1", 4);
      step(1'b0, 1'b0, 8'h00, "seq2", 8);
      step(1'b0, 1'b0, 8'h00, "seq3", 12);

      for (int i = 0; i < 80 && pc_m != 252; i++)
         step(1'b0, 1'b0, 8'h00, "to252", -1);
      tests++;
      assert (bus.PC === 8'd252)
      else begin
         fails++;
         $error("FAIL reach252: observed %0d expected 252", bus.PC);
      end
      step(1'b0, 1'b0, 8'h00, "wrap", 0);

      step(1'b0, 1'b0, 8'h00, "pre_br4", 4);
      step(1'b0, 1'b0, 8'h00, "pre_br8", 8);
      step(1'b0, 1'b1, 8'h10, "br_fwd", 24);
      step(1'b0, 1'b1, 8'hF8, "br_back", 16);
      step(1'b0, 1'b0, 8'h00, "br_seq", 20);

      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 8'h00, "hold", 20);

      step(1'b1, 1'b0, 8'h00, "rst_again", 0);
      step(1'b0, 1'b0, 8'h00, "pre_under", 4);
      step(1'b0, 1'b1, 8'hF8, "underflow", 252);

      step(1'b0, 1'b0, 8'h00, "wrap2", 0);
      step(1'b0, 1'b1, 8'h64, "br_to100", 100);
      step(1'b1, 1'b1, 8'h7F, "mid_rst", 0);
      step(1'b0, 1'b0, 8'h00, "post_rst", 4);

      step(1'b0, 1'b1, 8'h03, "odd_off", 7);
      step(1'b0, 1'b1, 8'h80, "min_off", 135);

      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), "random", -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
